// File: rtl/div_arbiter.sv
// div_arbiter
// Round-robin scheduler sharing one iterative signed divider among NREQ
// requesters. The winner's operands are latched, the divider is started
// with a single pulse, and the quotient is returned with a one-cycle done
// pulse to the winner. This block is the only driver of div_start.
//
// Optional feature macro: DIV_ARB_DIVZERO_EN
//   defined   : a zero denominator is answered locally (q_out = all ones,
//               err = 1) without starting the divider.
//   undefined : zero denominators go to the divider like any other; err = 0.

module div_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] n_in,
  input  logic [NREQ*W-1:0] d_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      q_out,
  output logic              err,
  output logic [W-1:0]      div_n,
  output logic [W-1:0]      div_d,
  output logic              div_start,
  input  logic              div_finished,
  input  logic [W-1:0]      div_q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   win_r;
  logic            err_r;

  logic            any_s;
  logic [PW-1:0]   pick_s;
  logic [PW:0]     sum_s;
  logic [NREQ-1:0] pick_oh_s;
  logic [W-1:0]    pick_n_s;
  logic [W-1:0]    pick_d_s;

  assign err = err_r;

  // Round-robin search: first requester at or after ptr, wrapping past NREQ-1.
  always_comb begin
    any_s  = 1'b0;
    pick_s = {PW{1'b0}};
    sum_s  = {(PW+1){1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr_r} + (PW+1)'(k);
      if (sum_s >= (PW+1)'(NREQ)) begin
        sum_s = sum_s - (PW+1)'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      if (!any_s && req[sum_s[PW-1:0]]) begin
        any_s  = 1'b1;
        pick_s = sum_s[PW-1:0];
      end else begin
        any_s  = any_s;
      end
    end
  end

  // Decode the winner into a one-hot grant and select its operand pair.
  always_comb begin
    pick_oh_s = {NREQ{1'b0}};
    pick_n_s  = {W{1'b0}};
    pick_d_s  = {W{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      if (pick_s == PW'(k)) begin
        pick_oh_s[k] = 1'b1;
        pick_n_s     = n_in[k*W +: W];
        pick_d_s     = d_in[k*W +: W];
      end else begin
        pick_oh_s[k] = 1'b0;
      end
    end
  end

  // Transaction FSM: grant/latch, start pulse, wait for divider, respond.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ptr_r     <= {PW{1'b0}};
      win_r     <= {PW{1'b0}};
      gnt       <= {NREQ{1'b0}};
      done      <= {NREQ{1'b0}};
      div_start <= 1'b0;
      q_out     <= {W{1'b0}};
      err_r     <= 1'b0;
      div_n     <= {W{1'b0}};
      div_d     <= {W{1'b0}};
    end else begin
      div_start <= 1'b0;
      done      <= {NREQ{1'b0}};
      case (state_r)
        ST_IDLE: begin
          // div_finished is deliberately ignored here: a result arriving
          // after an aborting reset must not be reported.
          if (any_s) begin
            win_r <= pick_s;
            gnt   <= pick_oh_s;
            div_n <= pick_n_s;
            div_d <= pick_d_s;
`ifdef DIV_ARB_DIVZERO_EN
            if (pick_d_s == {W{1'b0}}) begin
              q_out   <= {W{1'b1}};
              err_r   <= 1'b1;
              state_r <= ST_RESP;
            end else begin
              div_start <= 1'b1;
              state_r   <= ST_ISSUE;
            end
`else
            div_start <= 1'b1;
            state_r   <= ST_ISSUE;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // The start pulse is on the wire this cycle; a finished flag seen
          // now would belong to something else and is not looked at.
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (div_finished) begin
            q_out   <= div_q;
            err_r   <= 1'b0;
            state_r <= ST_RESP;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_RESP: begin
          // A requester that gave up keeps its done low; the slot still counts.
          done <= gnt & req;
          gnt  <= {NREQ{1'b0}};
          if (win_r == PW'(NREQ - 1)) begin
            ptr_r <= {PW{1'b0}};
          end else begin
            ptr_r <= win_r + PW'(1);
          end
          state_r <= ST_IDLE;
        end
        default: begin
          gnt     <= {NREQ{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: scoreboard fed at grant time by a
// round-robin reference model, drained by a monitor at transaction end.
module tb_div_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              ck = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] n_in = '0;
  logic [NREQ*W-1:0] d_in = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      q_out;
  logic              err;
  logic [W-1:0]      div_n;
  logic [W-1:0]      div_d;
  logic              div_start;
  logic              div_finished = 1'b0;
  logic [W-1:0]      div_q = '0;

  div_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .ck(ck), .rst_n(rst_n), .req(req), .n_in(n_in), .d_in(d_in),
    .gnt(gnt), .done(done), .q_out(q_out), .err(err),
    .div_n(div_n), .div_d(div_d), .div_start(div_start),
    .div_finished(div_finished), .div_q(div_q)
  );

  always #5 ck = ~ck;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Quotient the divider returns (zero denominator gives all ones).
  function automatic logic [W-1:0] ref_quot(input logic [W-1:0] n, input logic [W-1:0] d);
    if (d == '0) return '1;
    return W'($signed(n) / $signed(d));
  endfunction

  // Winner by rule: first requester at or after p, wrapping.
  function automatic int rr(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- divider model (not reset by rst_n) ----------------
  int          fixed_l = 0;
  int          div_cnt = 0;
  logic [W-1:0] div_res = '0;
  int          start_total = 0;
  logic [W-1:0] last_n = '0, last_d = '0;

  always @(posedge ck) begin
    div_finished <= 1'b0;
    div_q        <= W'($urandom);
    if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1) begin
        div_finished <= 1'b1;
        div_q        <= div_res;
      end
    end
    if (div_start === 1'b1) begin
      int l;
      l = (fixed_l > 0) ? fixed_l : int'($urandom_range(6, 1));
      start_total <= start_total + 1;
      last_n      <= div_n;
      last_d      <= div_d;
      if (l == 1) begin
        div_finished <= 1'b1;
        div_q        <= ref_quot(div_n, div_d);
      end else begin
        div_res <= ref_quot(div_n, div_d);
        div_cnt <= l - 1;
      end
    end
  end

  // ---------------- sampled inputs at each active edge ----------------
  logic [NREQ-1:0]   req_snap = '0;
  logic [NREQ*W-1:0] n_snap = '0, d_snap = '0;
  always @(posedge ck) begin
    req_snap <= req;
    n_snap   <= n_in;
    d_snap   <= d_in;
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    int           id;
    logic [W-1:0] n;
    logic [W-1:0] d;
    int           starts0;
  } txn_t;

  txn_t            sb[$];
  int              grant_log[$];
  int              mptr = 0;
  logic [NREQ-1:0] gnt_prev = '0;

  always @(negedge ck) begin
    if (!rst_n) begin
      sb.delete();
      mptr     = 0;
      gnt_prev = '0;
    end else begin
      if (gnt != gnt_prev) begin
        if (gnt_prev == '0) begin : on_grant
          int   w;
          txn_t e;
          w = rr(req_snap, mptr);
          for (int k = 0; k < NREQ; k++) if (gnt[k]) grant_log.push_back(k);
          if (w < 0) begin
            check("grant_without_req", 64'(gnt), 64'(0));
          end else begin
            check("grant", 64'(gnt), 64'(1) << w);
            e.id      = w;
            e.n       = n_snap[w*W +: W];
            e.d       = d_snap[w*W +: W];
            e.starts0 = start_total;
            sb.push_back(e);
            mptr = (w + 1) % NREQ;
          end
        end else if (gnt == '0) begin : on_end
          txn_t         e;
          logic [NREQ-1:0] exp_done;
          int           exp_st;
          logic [W-1:0] exp_q;
          logic         exp_err;
          if (sb.size() == 0) begin
            check("end_without_txn", 64'(sb.size()), 64'(1));
          end else begin
            e = sb.pop_front();
            exp_done = req_snap[e.id] ? (NREQ'(1) << e.id) : '0;
            exp_st   = 1;
            exp_q    = ref_quot(e.n, e.d);
            exp_err  = 1'b0;
`ifdef DIV_ARB_DIVZERO_EN
            if (e.d == '0) begin
              exp_st  = 0;
              exp_err = 1'b1;
            end
`endif
            check("done", 64'(done), 64'(exp_done));
            check("div_starts", 64'(start_total - e.starts0), 64'(exp_st));
            if (exp_st == 1 && start_total != e.starts0) begin
              check("div_n", 64'(last_n), 64'(e.n));
              check("div_d", 64'(last_d), 64'(e.d));
            end
            if (exp_done != '0) begin
              check("q_out", 64'(q_out), 64'(exp_q));
              check("err", 64'(err), 64'(exp_err));
            end
          end
        end else begin
          check("gnt_held", 64'(gnt), 64'(gnt_prev));
        end
      end else if (done != '0) begin
        check("spurious_done", 64'(done), 64'(0));
      end
      gnt_prev = gnt;
    end
  end

  // ---------------- requester agents ----------------
  logic hold1 = 1'b0;

  task automatic raise(input int i, input logic [W-1:0] n, input logic [W-1:0] d);
    n_in[i*W +: W] = n;
    d_in[i*W +: W] = d;
    req[i]         = 1'b1;
  endtask

  task automatic raise_rand(input int i);
    logic [W-1:0] n, d;
    n = W'($urandom_range(2000000)) - W'(1000000);
    if ($urandom_range(7) == 0) d = '0;
    else d = W'($urandom_range(600)) - W'(300);
    raise(i, n, d);
  endtask

  // One cycle of requester behaviour: drop on done, optional give-up,
  // optional new requests, optional operand scrambling after the latch.
  task automatic tick(input int p_raise, input int p_drop);
    @(negedge ck);
    for (int i = 0; i < NREQ; i++) begin
      if (done[i]) begin
        if (i == 1 && hold1) hold1 = 1'b0;
        else req[i] = 1'b0;
      end else if (req[i] && gnt[i] && p_drop > 0 && int'($urandom_range(99)) < p_drop) begin
        req[i] = 1'b0;
      end else if (!req[i] && !gnt[i] && p_raise > 0 && int'($urandom_range(99)) < p_raise) begin
        raise_rand(i);
      end
      if (gnt[i] && p_drop > 0 && $urandom_range(7) == 0) begin
        n_in[i*W +: W] = W'($urandom);
        d_in[i*W +: W] = W'($urandom);
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int c = 0;
    while (c < bound && !(sb.size() == 0 && gnt == '0 && req == '0)) begin
      tick(0, 0);
      c++;
    end
    tick(0, 0);
    check("idle_timeout", 64'(c < bound), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge ck);
    rst_n = 1'b0;
    req   = '0;
    @(negedge ck);
    @(negedge ck);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int gcyc, dcyc, c;
    logic seen;

    // Reset state
    @(negedge ck);
    @(negedge ck);
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_q", 64'(q_out), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_start", 64'(div_start), 64'(0));
    check("rst_div_n", 64'(div_n), 64'(0));
    check("rst_div_d", 64'(div_d), 64'(0));
    rst_n = 1'b1;
    tick(0, 0);

    // Single request, L=5: grant 1 cycle after req, done 8 cycles after req
    fixed_l = 5;
    raise(0, W'(100), W'(7));
    gcyc = -1; dcyc = -1;
    for (c = 1; c <= 40; c++) begin
      tick(0, 0);
      if (gnt[0] && gcyc < 0) gcyc = c;
      if (done[0]) begin dcyc = c; break; end
    end
    check("single_gnt_lat", 64'(gcyc), 64'(1));
    check("single_done_lat", 64'(dcyc), 64'(8));
    check("single_q", 64'(q_out), 64'(14));
    wait_idle(50);
    fixed_l = 0;

    // All four from reset: order 0,1,2,3
    do_reset();
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) raise_rand(i);
    wait_idle(200);
    check("all4_count", 64'(grant_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("all4_order", 64'(grant_log[i]), 64'(i));

    // Requester 1 keeps req after done while 2 pends: order 1,2,1
    do_reset();
    grant_log.delete();
    raise_rand(1);
    c = 0;
    while (!gnt[1] && c < 20) begin tick(0, 0); c++; end
    raise_rand(2);
    hold1 = 1'b1;
    wait_idle(200);
    check("hold_count", 64'(grant_log.size()), 64'(3));
    if (grant_log.size() == 3) begin
      check("hold_first", 64'(grant_log[0]), 64'(1));
      check("hold_second", 64'(grant_log[1]), 64'(2));
      check("hold_third", 64'(grant_log[2]), 64'(1));
    end

    // req[3] dropped in WAIT: no done for 3, next grant proceeds
    do_reset();
    grant_log.delete();
    fixed_l = 4;
    raise_rand(3);
    c = 0;
    while (!gnt[3] && c < 20) begin tick(0, 0); c++; end
    tick(0, 0);
    req[3] = 1'b0;
    raise_rand(1);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick(0, 0);
      if (done[3]) seen = 1'b1;
    end
    wait_idle(100);
    check("drop_no_done", 64'(seen), 64'(0));
    check("drop_count", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() == 2) check("drop_next", 64'(grant_log[1]), 64'(1));
    fixed_l = 0;

    // Zero denominator from requester 2
    c = start_total;
    raise(2, W'(50), W'(0));
    wait_idle(50);
`ifdef DIV_ARB_DIVZERO_EN
    check("dz_starts", 64'(start_total - c), 64'(0));
    check("dz_err", 64'(err), 64'(1));
`else
    check("dz_starts", 64'(start_total - c), 64'(1));
    check("dz_err", 64'(err), 64'(0));
`endif
    check("dz_q", 64'(q_out), 64'({W{1'b1}}));

    // Randomized traffic
    for (int k = 0; k < 3000; k++) tick(20, 2);
    wait_idle(300);

    // Reset asserted in WAIT, divider result arrives after release
    fixed_l = 6;
    raise_rand(0);
    c = 0;
    while (!gnt[0] && c < 20) begin tick(0, 0); c++; end
    tick(0, 0);
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("abort_gnt", 64'(gnt), 64'(0));
    check("abort_start", 64'(div_start), 64'(0));
    check("abort_q", 64'(q_out), 64'(0));
    check("abort_div_n", 64'(div_n), 64'(0));
    @(negedge ck);
    @(negedge ck);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(0, 0);
      if (done != '0 || gnt != '0 || div_start) seen = 1'b1;
    end
    check("abort_quiet", 64'(seen), 64'(0));
    check("abort_q_after", 64'(q_out), 64'(0));
    check("abort_err_after", 64'(err), 64'(0));
    fixed_l = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
